// File: rtl/key_shift_buffer.sv
// key_shift_buffer: keypad digit entry buffer with shift-in, backspace and clear.
// Slot 0 (low bits) holds the newest digit and the oldest digit falls out of the top.
// Optional macro KEY_SHIFT_EDGE_EN: requests act only on their 0->1 transition.
// With the macro undefined, requests act on every cycle they are sampled high.
module key_shift_buffer #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIGIT_W    = 4,
    parameter int unsigned KEY_MAX    = 9
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 shift,
    input  logic [DIGIT_W-1:0]                   key,
    input  logic                                 backspace,
    input  logic                                 clear,
    output logic [NUM_DIGITS*DIGIT_W-1:0]        key_buffer,
    output logic [$clog2(NUM_DIGITS+1)-1:0]      digit_count,
    output logic                                 full,
    output logic                                 key_error
);

    localparam int unsigned BUF_W = NUM_DIGITS * DIGIT_W;
    localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);

    // Qualified requests after optional edge detection.
    logic shift_req;
    logic backspace_req;
    logic clear_req;

    // Next-state values for the registered outputs.
    logic [BUF_W-1:0] buffer_next;
    logic [CNT_W-1:0] count_next;
    logic             error_next;
    logic             key_ok;

`ifdef KEY_SHIFT_EDGE_EN
    logic shift_prev;
    logic backspace_prev;
    logic clear_prev;

    // Previous request levels; cleared by reset so a request held through release acts once.
    always_ff @(posedge clock) begin
        if (!reset) begin
            shift_prev     <= 1'b0;
            backspace_prev <= 1'b0;
            clear_prev     <= 1'b0;
        end else begin
            shift_prev     <= shift;
            backspace_prev <= backspace;
            clear_prev     <= clear;
        end
    end

    // Rising-edge qualification of each request.
    always_comb begin
        shift_req     = shift & ~shift_prev;
        backspace_req = backspace & ~backspace_prev;
        clear_req     = clear & ~clear_prev;
    end
`else
    // Level mode: requests pass straight through.
    always_comb begin
        shift_req     = shift;
        backspace_req = backspace;
        clear_req     = clear;
    end
`endif

    // Command decode with priority clear > backspace > shift.
    always_comb begin
        buffer_next = key_buffer;
        count_next  = digit_count;
        error_next  = 1'b0;
        key_ok      = (32'(key) <= KEY_MAX);

        if (clear_req) begin
            buffer_next = '0;
            count_next  = '0;
        end else if (backspace_req) begin
            if (digit_count != '0) begin
                buffer_next = key_buffer >> DIGIT_W;
                count_next  = digit_count - CNT_W'(1);
            end
        end else if (shift_req) begin
            if (key_ok) begin
                buffer_next = (key_buffer << DIGIT_W) | BUF_W'(key);
                if (digit_count != CNT_W'(NUM_DIGITS)) begin
                    count_next = digit_count + CNT_W'(1);
                end
            end else begin
                error_next = 1'b1;
            end
        end
    end

    // Output registers; full is computed from the same next count so it tracks digit_count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            key_buffer  <= '0;
            digit_count <= '0;
            full        <= 1'b0;
            key_error   <= 1'b0;
        end else begin
            key_buffer  <= buffer_next;
            digit_count <= count_next;
            full        <= (count_next == CNT_W'(NUM_DIGITS));
            key_error   <= error_next;
        end
    end

endmodule

// File: tb/tb_key_shift_buffer.sv
// Testbench for key_shift_buffer (default parameters) with a queue-based reference model.
module tb_key_shift_buffer;

    localparam int unsigned ND = 4;
    localparam int unsigned DW = 4;
    localparam int unsigned KMAX = 9;

    logic        clock;
    logic        reset;
    logic        shift;
    logic [3:0]  key;
    logic        backspace;
    logic        clear;
    logic [15:0] key_buffer;
    logic [2:0]  digit_count;
    logic        full;
    logic        key_error;

    int nchecks = 0;
    int nerrors = 0;

    // Reference model: digits[0] is newest.
    int unsigned digits[$];
    logic        m_err;
    logic        p_sh, p_bs, p_cl;

    key_shift_buffer #(.NUM_DIGITS(ND), .DIGIT_W(DW), .KEY_MAX(KMAX)) dut (
        .clock       (clock),
        .reset       (reset),
        .shift       (shift),
        .key         (key),
        .backspace   (backspace),
        .clear       (clear),
        .key_buffer  (key_buffer),
        .digit_count (digit_count),
        .full        (full),
        .key_error   (key_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] model_buf();
        logic [15:0] v = '0;
        for (int i = 0; i < digits.size(); i++) v = v | (16'(digits[i]) << (i * DW));
        return v;
    endfunction

    task automatic model_apply(input logic r, input logic sh, input logic [3:0] k,
                               input logic bs, input logic cl);
        logic s, b, c;
        m_err = 1'b0;
        if (!r) begin
            digits.delete();
            p_sh = 1'b0; p_bs = 1'b0; p_cl = 1'b0;
        end else begin
`ifdef KEY_SHIFT_EDGE_EN
            s = sh && !p_sh; b = bs && !p_bs; c = cl && !p_cl;
`else
            s = sh; b = bs; c = cl;
`endif
            if (c) digits.delete();
            else if (b) begin
                if (digits.size() > 0) void'(digits.pop_front());
            end else if (s) begin
                if (k <= KMAX) begin
                    digits.push_front(int'(k));
                    if (digits.size() > ND) void'(digits.pop_back());
                end else m_err = 1'b1;
            end
            p_sh = sh; p_bs = bs; p_cl = cl;
        end
    endtask

    task automatic cycle(input logic r, input logic sh, input logic [3:0] k,
                         input logic bs, input logic cl);
        reset = r; shift = sh; key = k; backspace = bs; clear = cl;
        @(posedge clock);
        model_apply(r, sh, k, bs, cl);
        #1;
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [3:0] k);
        cycle(1'b1, 1'b1, k, 1'b0, 1'b0);
        idle();
    endtask

    task automatic do_clear();
        cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        idle();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
            nchecks++;
            if (key_buffer !== 16'h0 || digit_count !== 3'd0 || full !== 1'b0 || key_error !== 1'b0) begin
                nerrors++;
                $display("FAIL reset_hold cyc=%0d buf=%h cnt=%0d full=%b err=%b want 0/0/0/0",
                         i, key_buffer, digit_count, full, key_error);
            end
        end
        // Shift still high as reset releases: exactly one push on the first cycle.
        cycle(1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
        nchecks++;
        if (key_buffer !== 16'h0003 || digit_count !== 3'd1) begin
            nerrors++;
            $display("FAIL reset_release buf=%h cnt=%0d want 0003/1", key_buffer, digit_count);
        end
        cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        idle();
        nchecks++;
        if (key_buffer !== 16'h0 || digit_count !== 3'd0) begin
            nerrors++;
            $display("FAIL reset_reapply buf=%h cnt=%0d want 0/0", key_buffer, digit_count);
        end
    endtask

    task automatic test_fill_saturate();
        push(4'h1);
        nchecks++;
        if (key_buffer !== 16'h0001 || digit_count !== 3'd1 || full !== 1'b0) begin
            nerrors++;
            $display("FAIL fill_first buf=%h cnt=%0d full=%b want 0001/1/0", key_buffer, digit_count, full);
        end
        push(4'h2); push(4'h3); push(4'h4);
        nchecks++;
        if (key_buffer !== 16'h1234 || digit_count !== 3'd4 || full !== 1'b1) begin
            nerrors++;
            $display("FAIL fill_full buf=%h cnt=%0d full=%b want 1234/4/1", key_buffer, digit_count, full);
        end
        push(4'h5);
        nchecks++;
        if (key_buffer !== 16'h2345 || digit_count !== 3'd4 || full !== 1'b1) begin
            nerrors++;
            $display("FAIL fill_saturate buf=%h cnt=%0d full=%b want 2345/4/1", key_buffer, digit_count, full);
        end
    endtask

    task automatic test_reject();
        do_clear();
        push(4'h1); push(4'h2);
        cycle(1'b1, 1'b1, 4'hA, 1'b0, 1'b0);
        nchecks++;
        if (key_error !== 1'b1 || key_buffer !== 16'h0012 || digit_count !== 3'd2) begin
            nerrors++;
            $display("FAIL reject_pulse err=%b buf=%h cnt=%0d want 1/0012/2", key_error, key_buffer, digit_count);
        end
        idle();
        nchecks++;
        if (key_error !== 1'b0 || key_buffer !== 16'h0012) begin
            nerrors++;
            $display("FAIL reject_end err=%b buf=%h want 0/0012", key_error, key_buffer);
        end
        push(4'h9);
        nchecks++;
        if (key_error !== 1'b0 || key_buffer !== 16'h0129 || digit_count !== 3'd3) begin
            nerrors++;
            $display("FAIL accept_max err=%b buf=%h cnt=%0d want 0/0129/3", key_error, key_buffer, digit_count);
        end
    endtask

    task automatic test_backspace();
        do_clear();
        push(4'h1); push(4'h2); push(4'h3);
        cycle(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
        idle();
        nchecks++;
        if (key_buffer !== 16'h0012 || digit_count !== 3'd2) begin
            nerrors++;
            $display("FAIL bs_single buf=%h cnt=%0d want 0012/2", key_buffer, digit_count);
        end
        cycle(1'b1, 1'b1, 4'h7, 1'b1, 1'b0);
        nchecks++;
        if (key_buffer !== 16'h0001 || digit_count !== 3'd1 || key_error !== 1'b0) begin
            nerrors++;
            $display("FAIL bs_over_shift buf=%h cnt=%0d err=%b want 0001/1/0", key_buffer, digit_count, key_error);
        end
        idle();
        do_clear();
        cycle(1'b1, 1'b1, 4'hF, 1'b1, 1'b0);
        nchecks++;
        if (key_buffer !== 16'h0 || digit_count !== 3'd0 || key_error !== 1'b0) begin
            nerrors++;
            $display("FAIL bs_empty buf=%h cnt=%0d err=%b want 0/0/0", key_buffer, digit_count, key_error);
        end
        idle();
    endtask

    task automatic test_clear_priority();
        do_clear();
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        cycle(1'b1, 1'b1, 4'h5, 1'b1, 1'b1);
        nchecks++;
        if (key_buffer !== 16'h0 || digit_count !== 3'd0 || full !== 1'b0 || key_error !== 1'b0) begin
            nerrors++;
            $display("FAIL clear_all buf=%h cnt=%0d full=%b err=%b want 0/0/0/0",
                     key_buffer, digit_count, full, key_error);
        end
        idle();
        push(4'h8);
        cycle(1'b1, 1'b1, 4'hC, 1'b0, 1'b1);
        nchecks++;
        if (key_buffer !== 16'h0 || key_error !== 1'b0) begin
            nerrors++;
            $display("FAIL clear_bad_key buf=%h err=%b want 0/0", key_buffer, key_error);
        end
        idle();
    endtask

    task automatic test_hold();
        do_clear();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 4'h6, 1'b0, 1'b0);
        nchecks++;
`ifdef KEY_SHIFT_EDGE_EN
        if (key_buffer !== 16'h0006 || digit_count !== 3'd1) begin
            nerrors++;
            $display("FAIL hold_edge buf=%h cnt=%0d want 0006/1", key_buffer, digit_count);
        end
`else
        if (key_buffer !== 16'h0666 || digit_count !== 3'd3) begin
            nerrors++;
            $display("FAIL hold_level buf=%h cnt=%0d want 0666/3", key_buffer, digit_count);
        end
`endif
        idle();
    endtask

    task automatic test_mid_reset();
        do_clear();
        push(4'h8); push(4'h9);
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        idle();
        nchecks++;
        if (key_buffer !== 16'h0 || digit_count !== 3'd0 || full !== 1'b0) begin
            nerrors++;
            $display("FAIL mid_reset buf=%h cnt=%0d full=%b want 0/0/0", key_buffer, digit_count, full);
        end
        push(4'h2);
        nchecks++;
        if (key_buffer !== 16'h0002 || digit_count !== 3'd1) begin
            nerrors++;
            $display("FAIL mid_reset_resume buf=%h cnt=%0d want 0002/1", key_buffer, digit_count);
        end
    endtask

    task automatic test_random();
        logic r, sh, bs, cl;
        logic [3:0] k;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) != 0);
            sh = 1'($urandom_range(0, 1));
            k  = 4'($urandom_range(0, 11));
            bs = ($urandom_range(0, 5) == 0);
            cl = ($urandom_range(0, 15) == 0);
            cycle(r, sh, k, bs, cl);
            nchecks++;
            if (key_buffer !== model_buf() || digit_count !== 3'(digits.size()) ||
                full !== (digits.size() == ND) || key_error !== m_err) begin
                nerrors++;
                $display("FAIL random i=%0d buf=%h cnt=%0d full=%b err=%b want %h/%0d/%b/%b",
                         i, key_buffer, digit_count, full, key_error,
                         model_buf(), digits.size(), (digits.size() == ND), m_err);
            end
        end
    endtask

    initial begin
        reset = 1'b0; shift = 1'b0; key = 4'h0; backspace = 1'b0; clear = 1'b0;
        m_err = 1'b0; p_sh = 1'b0; p_bs = 1'b0; p_cl = 1'b0;
        test_reset();
        test_fill_saturate();
        test_reject();
        test_backspace();
        test_clear_priority();
        test_hold();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
